// File: rtl/dcache_data_memory_if.sv
// Line-granular request/ack bus between the data cache (master) and its backing
// data memory (slave): one 256-bit line per request, one-cycle ack on completion.
interface dcache_data_memory_if;
    logic         enable_i;
    logic         write_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         ack_o;
    logic [255:0] data_o;
    logic         proto_err_o;

    modport master (
        output enable_i,
        output write_i,
        output addr_i,
        output data_i,
        input  ack_o,
        input  data_o,
        input  proto_err_o
    );

    modport slave (
        input  enable_i,
        input  write_i,
        input  addr_i,
        input  data_i,
        output ack_o,
        output data_o,
        output proto_err_o
    );
endinterface

// File: rtl/dcache_data_memory.sv
// Fixed-latency 256-bit line memory serving data-cache refills and writebacks.
// Optional sticky protocol checker enabled by defining DMEM_PROTOCOL_CHECK_EN.
module dcache_data_memory #(
    parameter int unsigned LATENCY    = 10,
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    dcache_data_memory_if.slave  mem_bus
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned IDX_HI = DEPTH_LOG2 + 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [7:0]              r_cnt;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic                    r_wr;
    logic [255:0]            r_wdata;
    logic                    r_ack;
    logic [255:0]            r_rdata;
    logic [255:0]            r_mem [DEPTH];

    logic [DEPTH_LOG2-1:0]   w_in_idx;
    logic                    w_capture;
    logic                    w_commit;
    logic [DEPTH_LOG2-1:0]   w_sel_idx;
    logic                    w_sel_wr;
    logic [255:0]            w_sel_data;
    logic                    w_unused_addr;

    assign w_in_idx      = mem_bus.addr_i[IDX_HI:5];
    assign w_unused_addr = ^{mem_bus.addr_i[31:IDX_HI+1], mem_bus.addr_i[4:0]};

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, capture/commit strobes and the transaction operand select.
    // With LATENCY=1 the commit happens on the capture edge, so the live inputs
    // are selected in IDLE instead of the captured copy.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_commit     = 1'b0;
        w_sel_idx    = r_idx;
        w_sel_wr     = r_wr;
        w_sel_data   = r_wdata;
        case (r_state)
            ST_IDLE: begin
                w_sel_idx  = w_in_idx;
                w_sel_wr   = mem_bus.write_i;
                w_sel_data = mem_bus.data_i;
                if (mem_bus.enable_i) begin
                    w_capture = 1'b1;
                    if (LATENCY == 32'd1) begin
                        w_next_state = ST_ACK;
                        w_commit     = 1'b1;
                    end else begin
                        w_next_state = ST_BUSY;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (r_cnt == 8'd1) begin
                    w_next_state = ST_ACK;
                    w_commit     = 1'b1;
                end else begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_ACK: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request capture, latency counter, ack pulse and read data register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cnt   <= 8'd0;
            r_idx   <= '0;
            r_wr    <= 1'b0;
            r_wdata <= 256'd0;
            r_ack   <= 1'b0;
            r_rdata <= 256'd0;
        end else begin
            r_ack <= w_commit;
            if (w_capture) begin
                r_idx   <= w_in_idx;
                r_wr    <= mem_bus.write_i;
                r_wdata <= mem_bus.data_i;
                r_cnt   <= 8'(LATENCY - 32'd1);
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_commit && !w_sel_wr) begin
                r_rdata <= r_mem[w_sel_idx];
            end
        end
    end

    // Line storage; never cleared, and a write cut short by reset never lands
    always_ff @(posedge clk_i) begin
        if (rst_i && w_commit && w_sel_wr) begin
            r_mem[w_sel_idx] <= w_sel_data;
        end
    end

    assign mem_bus.ack_o  = r_ack;
    assign mem_bus.data_o = r_rdata;

`ifdef DMEM_PROTOCOL_CHECK_EN
    logic r_proto_err;
    logic w_violation;

    // The cache must hold a stable request until ack
    always_comb begin
        w_violation = 1'b0;
        if (r_state == ST_BUSY) begin
            w_violation = !mem_bus.enable_i
                        || (w_in_idx != r_idx)
                        || (mem_bus.write_i != r_wr)
                        || (r_wr && (mem_bus.data_i != r_wdata));
        end else begin
            w_violation = 1'b0;
        end
    end

    // Sticky violation flag, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_proto_err <= 1'b0;
        end else if (w_violation) begin
            r_proto_err <= 1'b1;
        end
    end

    assign mem_bus.proto_err_o = r_proto_err;
`else
    assign mem_bus.proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_data_memory.sv
// Self-checking bench: vector table, hand-written corner sequences and a random
// phase checked against a line-indexed reference model.
module tb_dcache_data_memory;

    logic clk;
    logic rst_i;
    int   n_total;
    int   n_pass;

    dcache_data_memory_if bus ();
    dcache_data_memory_if bus1 ();

    dcache_data_memory #(.LATENCY(10), .DEPTH_LOG2(9)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .mem_bus (bus)
    );

    dcache_data_memory #(.LATENCY(1), .DEPTH_LOG2(9)) dut1 (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .mem_bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DMEM_PROTOCOL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    localparam logic [255:0] DB = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] CF = {8{32'hCAFE_F00D}};
    localparam logic [255:0] L1 = {8{32'h1234_5678}};
    localparam logic [255:0] A5 = {8{32'hA5A5_A5A5}};
    localparam logic [255:0] C0 = {8{32'h0C0C_0C0C}};
    localparam logic [255:0] Z0 = {8{32'h0000_1111}};
    localparam logic [255:0] D2 = {8{32'h8888_0800}};
    localparam logic [255:0] D4 = {8{32'hBAD0_1000}};
    localparam logic [255:0] D5 = {8{32'h5555_02A0}};
    localparam logic [255:0] D6 = {8{32'h6666_1400}};

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] exp_rd;
    } vec_t;

    vec_t vecs [12];

    logic [255:0] m_mem [int];
    logic [255:0] m_dout;

    function automatic void check(input string name, input logic [255:0] act,
                                  input logic [255:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic run_txn(input logic wr, input logic [31:0] addr,
                           input logic [255:0] wd, output int lat,
                           output logic [255:0] rd);
        bus.enable_i = 1'b1;
        bus.write_i  = wr;
        bus.addr_i   = addr;
        bus.data_i   = wd;
        lat = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.ack_o) break;
        end
        if (!bus.ack_o) lat = -1;
        rd = bus.data_o;
        bus.enable_i = 1'b0;
        @(posedge clk);
        #1;
        check("ack_single_pulse", 256'(bus.ack_o), 256'd0);
    endtask

    initial begin
        int           lat;
        int           n1;
        logic [255:0] rd;
        logic [255:0] d;
        logic [31:0]  a;
        logic         wr;
        int           idx;

        n_total = 0;
        n_pass  = 0;

        vecs[0]  = '{1'b1, 32'h0000_0400, DB,      256'd0};
        vecs[1]  = '{1'b0, 32'h0000_0400, 256'd0,  DB};
        vecs[2]  = '{1'b1, 32'h0000_041C, CF,      DB};
        vecs[3]  = '{1'b0, 32'h0004_0400, 256'd0,  CF};
        vecs[4]  = '{1'b1, 32'h0000_1000, L1,      CF};
        vecs[5]  = '{1'b1, 32'h0000_3FE0, A5,      CF};
        vecs[6]  = '{1'b1, 32'h0000_0C00, C0,      CF};
        vecs[7]  = '{1'b0, 32'h0000_3FE0, 256'd0,  A5};
        vecs[8]  = '{1'b0, 32'h0000_1000, 256'd0,  L1};
        vecs[9]  = '{1'b1, 32'h0000_0000, Z0,      L1};
        vecs[10] = '{1'b0, 32'hFFFF_C000, 256'd0,  Z0};
        vecs[11] = '{1'b0, 32'h0000_0C00, 256'd0,  C0};

        bus.enable_i  = 1'b0;  bus.write_i  = 1'b0;
        bus.addr_i    = 32'd0; bus.data_i   = 256'd0;
        bus1.enable_i = 1'b0;  bus1.write_i = 1'b0;
        bus1.addr_i   = 32'd0; bus1.data_i  = 256'd0;
        rst_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", 256'(bus.ack_o), 256'd0);
        check("reset_data", bus.data_o, 256'd0);
        check("reset_proto_err", 256'(bus.proto_err_o), 256'd0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;

        // Vector table: write/read, offset bits, upper-bit aliasing, index extremes
        for (int v = 0; v < 12; v++) begin
            run_txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, lat, rd);
            check($sformatf("vec%0d_latency", v), 256'(lat), 256'd10);
            check($sformatf("vec%0d_data", v), rd, vecs[v].exp_rd);
        end

        // Writeback then refill with enable held across the ack
        bus.enable_i = 1'b1; bus.write_i = 1'b1;
        bus.addr_i = 32'h0000_0800; bus.data_i = D2;
        n1 = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            if (bus.ack_o) begin n1 = i; break; end
        end
        check("wb_latency", 256'(n1), 256'd10);
        bus.write_i = 1'b0; bus.addr_i = 32'h0000_0C00;
        n1 = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            if (bus.ack_o) begin n1 = i; break; end
        end
        check("refill_ack_spacing", 256'(n1), 256'd11);
        check("refill_data", bus.data_o, C0);
        bus.enable_i = 1'b0;
        @(posedge clk);
        #1;
        run_txn(1'b0, 32'h0000_0800, 256'd0, lat, rd);
        check("wb_committed", rd, D2);

        // Reset in the middle of a write to 0x1000 discards it
        bus.enable_i = 1'b1; bus.write_i = 1'b1;
        bus.addr_i = 32'h0000_1000; bus.data_i = D4;
        repeat (5) @(posedge clk);
        #1;
        rst_i = 1'b0; bus.enable_i = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_ack", 256'(bus.ack_o), 256'd0);
        check("midreset_data", bus.data_o, 256'd0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            check("midreset_no_ack", 256'(bus.ack_o), 256'd0);
            @(posedge clk);
            #1;
        end
        run_txn(1'b0, 32'h0000_1000, 256'd0, lat, rd);
        check("midreset_prior_line", rd, L1);

        // Random phase on lines 100..115 against the reference model
        m_dout = L1;
        for (int t = 0; t < 40; t++) begin
            idx = 100 + int'($urandom_range(0, 15));
            wr  = !m_mem.exists(idx) || ($urandom_range(0, 1) == 1);
            a   = $urandom;
            a[13:5] = 9'(idx);
            for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
            run_txn(wr, a, d, lat, rd);
            check("rand_latency", 256'(lat), 256'd10);
            if (wr) begin
                m_mem[idx] = d;
            end else begin
                m_dout = m_mem[idx];
            end
            check("rand_data", rd, m_dout);
        end

        // Enable dropped during BUSY: transaction completes, checker flags it
        bus.enable_i = 1'b1; bus.write_i = 1'b1;
        bus.addr_i = 32'h0000_1400; bus.data_i = D6;
        n1 = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) bus.enable_i = 1'b0;
            if (bus.ack_o) begin n1 = i; break; end
        end
        check("drop_en_latency", 256'(n1), 256'd10);
        check("drop_en_proto_err", 256'(bus.proto_err_o), 256'(EXP_ERR));
        run_txn(1'b0, 32'h0000_1400, 256'd0, lat, rd);
        check("drop_en_committed", rd, D6);
        check("proto_err_sticky", 256'(bus.proto_err_o), 256'(EXP_ERR));
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        check("proto_err_reset", 256'(bus.proto_err_o), 256'd0);

        // LATENCY=1 instance: ack on the capture edge, every 2nd cycle when held
        bus1.enable_i = 1'b1; bus1.write_i = 1'b1;
        bus1.addr_i = 32'h0000_02A0; bus1.data_i = D5;
        @(posedge clk);
        #1;
        check("l1_write_ack", 256'(bus1.ack_o), 256'd1);
        bus1.write_i = 1'b0;
        @(posedge clk);
        #1;
        check("l1_idle_gap", 256'(bus1.ack_o), 256'd0);
        @(posedge clk);
        #1;
        check("l1_read_ack", 256'(bus1.ack_o), 256'd1);
        check("l1_read_data", bus1.data_o, D5);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("l1_held_ack%0d", i), 256'(bus1.ack_o), 256'(i % 2));
        end
        bus1.enable_i = 1'b0;
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
